// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: one hold slot each for writeback and debug requesters,
// with writes committed only in the WRITE phase. The pending-address mask is built only
// when RF_WRITE_ARBITER_PEND_MASK_EN is defined.
module rf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    output logic        tick_tock,
    output logic        rf_regwrite,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pend_mask
);

    typedef enum logic {
        PH_WRITE = 1'b0,
        PH_READ  = 1'b1
    } phase_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    phase_t      phase;
    phase_t      phase_next;

    logic        wb_full;
    logic [4:0]  wb_slot_addr;
    logic [31:0] wb_slot_data;
    logic        dbg_full;
    logic [4:0]  dbg_slot_addr;
    logic [31:0] dbg_slot_data;
    logic [3:0]  starve;

    logic        grant_wb;
    logic        grant_dbg;
    logic        wb_take;
    logic        dbg_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= PH_READ;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next  = (phase == PH_READ) ? PH_WRITE : PH_READ;
        grant_wb    = 1'b0;
        grant_dbg   = 1'b0;
        rf_regwrite = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        if (phase == PH_WRITE) begin
            if (wb_full && dbg_full) begin
                if (starve == LIMIT) grant_dbg = 1'b1;
                else                 grant_wb  = 1'b1;
            end else if (wb_full) begin
                grant_wb = 1'b1;
            end else if (dbg_full) begin
                grant_dbg = 1'b1;
            end
        end
        // A grant to address 0 still retires the slot but never strobes the write enable
        if (grant_wb) begin
            rf_waddr    = wb_slot_addr;
            rf_wdata    = wb_slot_data;
            rf_regwrite = |wb_slot_addr;
        end else if (grant_dbg) begin
            rf_waddr    = dbg_slot_addr;
            rf_wdata    = dbg_slot_data;
            rf_regwrite = |dbg_slot_addr;
        end
    end

    assign tick_tock = (phase == PH_READ);
    assign wb_ready  = ~wb_full | grant_wb;
    assign dbg_ready = ~dbg_full | grant_dbg;
    assign wb_take   = wb_valid & wb_ready;
    assign dbg_take  = dbg_valid & dbg_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_full      <= 1'b0;
            wb_slot_addr <= '0;
            wb_slot_data <= '0;
        end else if (wb_take) begin
            wb_full      <= 1'b1;
            wb_slot_addr <= wb_addr;
            wb_slot_data <= wb_data;
        end else if (grant_wb) begin
            wb_full      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbg_full      <= 1'b0;
            dbg_slot_addr <= '0;
            dbg_slot_data <= '0;
        end else if (dbg_take) begin
            dbg_full      <= 1'b1;
            dbg_slot_addr <= dbg_addr;
            dbg_slot_data <= dbg_data;
        end else if (grant_dbg) begin
            dbg_full      <= 1'b0;
        end
    end

    // Counts wb wins only while dbg is actually waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (!dbg_full || grant_dbg) begin
            starve <= '0;
        end else if (grant_wb && (starve != LIMIT)) begin
            starve <= starve + 4'd1;
        end
    end

`ifdef RF_WRITE_ARBITER_PEND_MASK_EN
    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            pend_mask[i] = (wb_full && (wb_slot_addr == 5'(i))) ||
                           (dbg_full && (dbg_slot_addr == 5'(i)));
        end
    end
`else
    assign pend_mask = '0;
`endif

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive wb grants allowed while dbg waits (legal range 1..15).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 wb_valid  in  1  writeback requester has a write.
REQ-005 wb_addr  in  5  writeback destination register.
REQ-006 wb_data  in  32  writeback data.
REQ-007 wb_ready  out  1  wb hold slot can accept.
REQ-008 dbg_valid  in  1  debug/loader requester has a write.
REQ-009 dbg_addr  in  5  debug destination register.
REQ-010 dbg_data  in  32  debug data.
REQ-011 dbg_ready  out  1  dbg hold slot can accept.
REQ-012 tick_tock  out  1  register-file phase: 0 = write phase, 1 = read phase.
REQ-013 rf_regwrite  out  1  register-file write enable.
REQ-014 rf_waddr  out  5  register-file write address.
REQ-015 rf_wdata  out  32  register-file write data.
REQ-016 pend_mask  out  32  bit i set while any hold slot holds address i (i>0).

Function
REQ-017 Phase FSM, two states, READ (tick_tock=1) and WRITE (tick_tock=0), toggling every cycle, unconditionally.
REQ-018 Each requester owns one hold slot (full flag, addr, data); transfer occurs when valid & ready at a rising edge.
REQ-019 ready = ~full | (slot granted this cycle); accepting and retiring in the same cycle is legal and leaves the slot full with the new entry.
REQ-020 Grant is evaluated only in WRITE; in READ no grant, rf_regwrite=0.
REQ-021 In WRITE with exactly one slot full, that slot is granted.
REQ-022 In WRITE with both full: wb granted unless starve counter == STARVE_LIMIT, then dbg granted.
REQ-023 Starve counter (4 bits) increments on each wb grant while dbg slot full; clears on dbg grant or whenever dbg slot empty; saturates at STARVE_LIMIT.
REQ-024 Granted slot drives rf_waddr/rf_wdata combinationally in that cycle; rf_regwrite=1 unless its addr==0.
REQ-025 Grant to addr 0 is consumed: slot clears, rf_regwrite=0, no register update.
REQ-026 When no grant, rf_waddr=0, rf_wdata=0, rf_regwrite=0.
REQ-027 Minimum latency: accept at edge N, commit in first WRITE cycle after edge N (1 or 2 cycles).
REQ-028 Both slots holding the same address commit in grant order; the later commit is the final register value.
REQ-029 A slot is never granted in the same cycle it is filled; the filling edge ends that cycle.

Reset
REQ-030 While rst=0: tick_tock=1 (READ), both slots empty, starve counter 0, rf_regwrite=0, rf_waddr=0, rf_wdata=0, pend_mask=0, wb_ready=1, dbg_ready=1.
REQ-031 Reset assertion mid-operation discards slot contents without committing; first cycle after deassertion is READ.

Configuration
REQ-032 Macro RF_WRITE_ARBITER_PEND_MASK_EN: defined -> pend_mask per REQ-016; undefined -> pend_mask tied to 32'h0 and no mask logic synthesized.

Verification
REQ-033 Reset release, no traffic -> tick_tock 1,0,1,0...; rf_regwrite never 1; both readies 1.
REQ-034 wb write x5=32'hDEADBEEF accepted in READ cycle -> next cycle WRITE with rf_regwrite=1, rf_waddr=5, rf_wdata=32'hDEADBEEF; slot empties.
REQ-035 wb and dbg held continuously valid (wb x1..., dbg x2=32'h1234), STARVE_LIMIT=4 -> 4 wb commits then dbg x2 commit on 5th WRITE phase; counter clears.
REQ-036 dbg write x0=32'hFFFFFFFF -> slot consumed in next WRITE, rf_regwrite stays 0.
REQ-037 wb x7=32'hA then dbg x7=32'hB both pending -> commits wb then dbg; x7 final 32'hB; with macro, pend_mask[7]=1 until second commit, 0 after.
REQ-038 rst asserted while both slots full -> outputs jump to REQ-030 values immediately; pending writes never appear on rf_regwrite.
